// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock parametrised FIFO.
// Provides the depth and pointer-width derivations, the legality checks
// for the size and threshold parameters, and the operation encoding the
// occupancy counter decodes.
package sync_fifo_pkg;

  // Accepted-operation encoding: {write accepted, read accepted}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  localparam int ADDR_SIZE_MIN = 2;
  localparam int ADDR_SIZE_MAX = 10;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  // One extra wrap bit above the RAM address bits
  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

  function automatic bit addr_size_ok(input int addr_size);
    return (addr_size >= ADDR_SIZE_MIN) && (addr_size <= ADDR_SIZE_MAX);
  endfunction

  function automatic bit af_level_ok(input int addr_size, input int af_level);
    return (af_level >= 1) && (af_level <= fifo_depth(addr_size));
  endfunction

  function automatic bit ae_level_ok(input int addr_size, input int ae_level);
    return (ae_level >= 0) && (ae_level <= fifo_depth(addr_size) - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle of the single-clock FIFO.
// master: the block that pushes/pops (drives wr, rd, data_in, clr_err).
// slave : the FIFO itself (drives data, flags, count, error flags).
interface sync_fifo_param_if #(
  parameter int addr_size  = 3,
  parameter int word_width = 8
);
  logic                  wr;
  logic                  rd;
  logic [word_width-1:0] data_in;
  logic                  clr_err;
  logic [word_width-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [addr_size:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, rd, data_in, clr_err,
    input  data_out, full, empty, almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr, rd, data_in, clr_err,
    output data_out, full, empty, almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_ram.sv
// fifo_ram: DEPTH x word_width storage for the single-clock FIFO.
// Synchronous write on clk, asynchronous read by address. No reset: the
// contents are only meaningful between the FIFO pointers.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int addr_size  = 3,
  parameter int word_width = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [addr_size-1:0]  waddr_i,
  input  logic [word_width-1:0] wdata_i,
  input  logic [addr_size-1:0]  raddr_i,
  output logic [word_width-1:0] rdata_o
);
  localparam int DEPTH = fifo_depth(addr_size);

  logic [word_width-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Ports: clk, reset_n (async, active low), bus (sync_fifo_param_if.slave:
//   wr, rd, data_in, clr_err in; data_out, full, empty, almost_full,
//   almost_empty, count, overflow, underflow out).
// Build option FIFO_FWFT_EN: when defined, data_out shows the head word
//   combinationally (first-word-fall-through); otherwise data_out is a
//   register loaded on each accepted read and reset to 0.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int addr_size  = 3,
  parameter int word_width = 8,
  parameter int af_level   = (1 << addr_size) - 1,
  parameter int ae_level   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  sync_fifo_param_if.slave bus
);
  localparam int PW = ptr_width(addr_size);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  fifo_op_e              op;
  logic [word_width-1:0] ram_rdata;

  // Wrap bits differ with equal addresses only when a full lap ahead
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[addr_size-1:0] == rd_ptr_q[addr_size-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign wr_acc = bus.wr && !full;
  assign rd_acc = bus.rd && !empty;
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case (op)
      OP_WR:   count_d = count_q + PW'(1);
      OP_RD:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  // A set request in the same cycle as clr_err keeps the flag set
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.wr && full) begin
      ovf_d = 1'b1;
    end else if (bus.clr_err) begin
      ovf_d = 1'b0;
    end
    if (bus.rd && empty) begin
      udf_d = 1'b1;
    end else if (bus.clr_err) begin
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram #(
    .addr_size  (addr_size),
    .word_width (word_width)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[addr_size-1:0]),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q[addr_size-1:0]),
    .rdata_o (ram_rdata)
  );

`ifdef FIFO_FWFT_EN
  assign bus.data_out = ram_rdata;
`else
  logic [word_width-1:0] dout_q, dout_d;

  assign dout_d = rd_acc ? ram_rdata : dout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= PW'(af_level));
  assign bus.almost_empty = (count_q <= PW'(ae_level));
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

`ifndef SYNTHESIS
  addr_size_legal: assert property (@(posedge clk) addr_size_ok(addr_size))
    else $error("sync_fifo_param: addr_size %0d out of range", addr_size);
  af_level_legal: assert property (@(posedge clk) af_level_ok(addr_size, af_level))
    else $error("sync_fifo_param: af_level %0d out of range", af_level);
  ae_level_legal: assert property (@(posedge clk) ae_level_ok(addr_size, ae_level))
    else $error("sync_fifo_param: ae_level %0d out of range", ae_level);
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param (addr_size 3, word_width 8, af_level 7,
// ae_level 1). A table of hand-computed status vectors drives the main
// fill/drain/error scenarios; a queue scoreboard checks read data; short
// hand sequences cover reset mid-stream, pointer wrap and FWFT timing.
module tb_sync_fifo_param;
  localparam int AW    = 3;
  localparam int WW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic reset_n;

  sync_fifo_param_if #(.addr_size(AW), .word_width(WW)) bus ();

  sync_fifo_param #(
    .addr_size  (AW),
    .word_width (WW),
    .af_level   (DEPTH - 1),
    .ae_level   (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic          clr;
    logic [WW-1:0] din;
    logic [9:0]    exp_stat;
  } vec_t;

  vec_t          tbl[$];
  logic [WW-1:0] sb[$];
  logic [WW-1:0] exp_dout;
  logic          m_ovf, m_udf;
  int            n_vec, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_stat();
    return {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
            bus.overflow, bus.underflow};
  endfunction

  function automatic logic [9:0] model_stat();
    int c;
    c = sb.size();
    return {4'(c), c == DEPTH, c == 0, c >= DEPTH - 1, c <= 1, m_ovf, m_udf};
  endfunction

  task automatic add(input logic w, input logic r, input logic c, input logic [WW-1:0] d,
                     input int cnt, input logic f, input logic e, input logic af,
                     input logic ae, input logic o, input logic u);
    tbl.push_back('{wr: w, rd: r, clr: c, din: d, exp_stat: {4'(cnt), f, e, af, ae, o, u}});
  endtask

  // One clock of stimulus; scoreboard/model updated on the accepting edge
  task automatic do_cycle(input logic w, input logic r, input logic [WW-1:0] d, input logic c);
    logic wacc, racc, mfull, mempty;
    @(negedge clk);
    bus.wr = w; bus.rd = r; bus.data_in = d; bus.clr_err = c;
    mfull  = (sb.size() == DEPTH);
    mempty = (sb.size() == 0);
    wacc   = w && !mfull;
    racc   = r && !mempty;
`ifdef FIFO_FWFT_EN
    if (racc) chk("fwft_head", 32'(bus.data_out), 32'(sb[0]));
`endif
    @(posedge clk);
    #1;
    if (racc) exp_dout = sb.pop_front();
    if (wacc) sb.push_back(d);
    if (w && mfull) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (r && mempty) m_udf = 1'b1;
    else if (c) m_udf = 1'b0;
    chk("model_status", 32'(dut_stat()), 32'(model_stat()));
`ifndef FIFO_FWFT_EN
    chk("read_data", 32'(bus.data_out), 32'(exp_dout));
`endif
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_ovf = 1'b0; m_udf = 1'b0; exp_dout = '0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.data_in = '0; bus.clr_err = 1'b0;
    reset_n = 1'b0;

    //   wr rd clr din    cnt f e af ae ovf udf
    for (int i = 1; i <= 8; i++)
      add(1, 0, 0, 8'(i), i, i == 8, 0, i >= 7, i <= 1, 0, 0);
    add(1, 0, 0, 8'hAA, 8, 1, 0, 1, 0, 1, 0);  // write while full
    add(0, 0, 1, 8'h00, 8, 1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 8'hAA, 8, 1, 0, 1, 0, 1, 0);  // set beats clear
    add(0, 0, 1, 8'h00, 8, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 8'hBB, 7, 0, 0, 1, 0, 1, 0);  // full: read only
    add(0, 0, 1, 8'h00, 7, 0, 0, 1, 0, 0, 0);
    for (int i = 6; i >= 0; i--)
      add(0, 1, 0, 8'h00, i, 0, i == 0, 0, i <= 1, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 1);  // read while empty
    add(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0);
    add(1, 1, 0, 8'h55, 1, 0, 0, 0, 1, 0, 1);  // empty: write only
    add(1, 1, 0, 8'h66, 1, 0, 0, 0, 1, 0, 1);  // both accepted
    add(0, 1, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0);
    add(1, 1, 1, 8'h77, 1, 0, 0, 0, 1, 0, 1);  // set beats clear
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0);

    #12;
    chk("reset_status", 32'(dut_stat()), 32'({4'd0, 6'b010100}));
`ifndef FIFO_FWFT_EN
    chk("reset_data_out", 32'(bus.data_out), 32'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      do_cycle(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].clr);
      chk($sformatf("vec%0d_status", i), 32'(dut_stat()), 32'(tbl[i].exp_stat));
    end

    // Reset mid-stream with five words buffered and overflow-free state
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    do_cycle(1'b1, 1'b0, 8'h15, 1'b0);
    chk("pre_reset_count", 32'(bus.count), 32'd5);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_count", 32'(bus.count), 32'd0);
    chk("midreset_flags", 32'({bus.empty, bus.full, bus.overflow, bus.underflow}), 32'b1000);
`ifndef FIFO_FWFT_EN
    chk("midreset_data_out", 32'(bus.data_out), 32'h0);
`endif
    sb.delete();
    m_ovf = 1'b0; m_udf = 1'b0; exp_dout = '0;
    @(negedge clk);
    reset_n = 1'b1;
    do_cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Pointer wrap: 20 writes overlapped with reads, 2.5 laps of the RAM
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b1, i > 0, 8'(8'h20 + i), 1'b0);
      chk("wrap_not_full", 32'(bus.full), 32'd0);
    end
    do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("wrap_drained", 32'(bus.empty), 32'd1);

`ifdef FIFO_FWFT_EN
    do_cycle(1'b1, 1'b0, 8'h3C, 1'b0);
    chk("fwft_fallthrough", 32'(bus.data_out), 32'h3C);
    do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_pop_empty", 32'(bus.empty), 32'd1);
`else
    // Registered mode: a write alone must not disturb data_out
    do_cycle(1'b1, 1'b0, 8'h3C, 1'b0);
    chk("reg_hold_on_write", 32'(bus.data_out), 32'h33);
    do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("reg_read_3c", 32'(bus.data_out), 32'h3C);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
